start_trigger_gen: RTL and testbench

START_TRIGGER_GEN -- requirements
Module: start_trigger_gen

---
 rtl/start_trigger_gen_if.sv | 11 +
 rtl/start_trigger_gen.sv | 94 +++++++++
 tb/tb_start_trigger_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/start_trigger_gen_if.sv
// Pushbutton/frame-valid inputs and conditioned start/status outputs of the start trigger generator.
interface start_trigger_gen_if;
  logic       key_n;
  logic       frame_valid;
  logic       start_out;
  logic       busy;
  logic [7:0] trig_count;

  modport slave  (input  key_n, frame_valid, output start_out, busy, trig_count);
  modport master (output key_n, frame_valid, input  start_out, busy, trig_count);
endinterface

// File: rtl/start_trigger_gen.sv
// Debounced pushbutton arms a one-shot start pulse that fires on the next camera frame-valid rise.
module start_trigger_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  start_trigger_gen_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, ARMED, HOLD, WAIT_REL} state_t;

  localparam logic [25:0] DEB_LAST  = 26'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [1:0]  key_sync, fv_sync;
  logic        fv_d, start_q, busy_q;
  logic [7:0]  trig_q;
  logic        key_s, fv_s, fv_rise;

  assign key_s   = key_sync[1];
  assign fv_s    = fv_sync[1];
  assign fv_rise = fv_s & ~fv_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (!key_s) begin
        state_d = DEBOUNCE;
        cnt_d   = '0;
      end
      DEBOUNCE: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 26'd1;
      end
      // Only a rise seen while already armed counts; fv_d tracks fv_s in every state.
      ARMED: if (fv_rise) begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 26'd1;
      end
      WAIT_REL: begin
        if (!key_s) cnt_d = '0;
        else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 26'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync <= 2'b11;
      fv_sync  <= 2'b00;
      fv_d     <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      trig_q   <= '0;
    end else begin
      key_sync <= {key_sync[0], bus.key_n};
      fv_sync  <= {fv_sync[0], bus.frame_valid};
      fv_d     <= fv_s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // Outputs are decoded from next state so they are flops aligned with state_q.
      start_q  <= (state_d == HOLD);
      busy_q   <= (state_d != IDLE);
      if (state_q == ARMED && state_d == HOLD) trig_q <= trig_q + 8'd1;
    end
  end

  assign bus.start_out  = start_q;
  assign bus.busy       = busy_q;
  assign bus.trig_count = trig_q;
endmodule

// File: tb/tb_start_trigger_gen.sv
// Scoreboard bench: expected start pulses are queued at stimulus time and matched as start_out pulses appear.
module tb_start_trigger_gen;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_trig = 0;

  typedef struct { int start_cyc; int len; int cnt; } exp_t;
  exp_t q[$];

  start_trigger_gen_if bus();

  start_trigger_gen #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_pulse(input int start_cyc, input int len);
    exp_t e;
    exp_trig    = (exp_trig + 1) % 256;
    e.start_cyc = start_cyc;
    e.len       = len;
    e.cnt       = exp_trig;
    q.push_back(e);
  endtask

  // Release the key after the pulse; busy must drop after 4 released cycles.
  task automatic release_chk();
    int r;
    bus.frame_valid = 1'b0;
    bus.key_n       = 1'b1;
    r = cyc;
    wait_to(r + 5); chk("busy_relwait", bus.busy, 1);
    wait_to(r + 6); chk("busy_idle", bus.busy, 0);
  endtask

  task automatic full_seq(input int gap, input bit pre_fv);
    int c, f;
    c = cyc;
    bus.key_n = 1'b0;
    if (pre_fv) bus.frame_valid = 1'b1;
    wait_to(c + 2); chk("busy_pre", bus.busy, 0);
    wait_to(c + 3); chk("busy_deb", bus.busy, 1);
    if (pre_fv) begin
      wait_to(c + 12);
      chk("prefv_notrig", bus.trig_count, exp_trig);
      bus.frame_valid = 1'b0;
      wait_to(c + 15);
    end else wait_to(c + 7 + gap);
    f = cyc;
    bus.frame_valid = 1'b1;
    push_pulse(f + 3, 3);
    wait_to(f + 7);
    release_chk();
  endtask

  // Pulse monitor: every rise must match a queued expectation.
  bit   prev = 1'b0;
  bit   active = 1'b0;
  int   run_len = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (bus.start_out && !prev) begin
      if (q.size() == 0) begin
        chk("unexp_pulse", cyc, -1);
        active = 1'b0;
      end else begin
        cur = q.pop_front();
        active = 1'b1;
        chk("start_cyc", cyc, cur.start_cyc);
        chk("trig_at_rise", int'(bus.trig_count), cur.cnt);
      end
      run_len = 1;
    end else if (bus.start_out) run_len++;
    else if (prev && active) chk("pulse_len", run_len, cur.len);
    prev = bus.start_out;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, f, s;
    reset = 1'b1;
    bus.key_n = 1'b1;
    bus.frame_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", bus.start_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_trig", bus.trig_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Short press: debounce aborts, frame_valid pulses ignored.
    c = cyc;
    bus.key_n = 1'b0;
    wait_to(c + 3); chk("short_busy", bus.busy, 1);
    bus.key_n = 1'b1;
    wait_to(c + 4); bus.frame_valid = 1'b1;
    wait_to(c + 6); chk("short_idle", bus.busy, 0);
    bus.frame_valid = 1'b0;
    wait_to(c + 12); bus.frame_valid = 1'b1;
    wait_to(c + 16); bus.frame_valid = 1'b0;
    chk("short_trig", bus.trig_count, 0);
    wait_to(c + 20);

    // 256 full sequences wrap trig_count back to its start.
    for (int i = 0; i < 256; i++) full_seq(i % 3, 1'b0);
    wait_to(cyc + 2);
    chk("wrap_trig", bus.trig_count, 0);

    // Frame rises 5 cycles after arming.
    full_seq(5, 1'b0);
    // frame_valid already high before arming.
    full_seq(0, 1'b1);

    // Key held 100 cycles with frame_valid toggling: one pulse only.
    c = cyc;
    bus.key_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      wait_to(c + 8 * k);
      if (!bus.frame_valid) begin
        if (k == 1) push_pulse(cyc + 3, 3);
      end
      bus.frame_valid = ~bus.frame_valid;
    end
    wait_to(c + 100);
    chk("hold_trig", bus.trig_count, exp_trig);
    release_chk();

    // Reset on second HOLD cycle, key still held afterwards.
    c = cyc;
    bus.key_n = 1'b0;
    wait_to(c + 8);
    f = cyc;
    bus.frame_valid = 1'b1;
    push_pulse(f + 3, 1);
    s = f + 3;
    wait_to(s);
    reset = 1'b1;
    wait_to(s + 1);
    chk("rst_hold_start", bus.start_out, 0);
    chk("rst_hold_busy", bus.busy, 0);
    chk("rst_hold_trig", bus.trig_count, 0);
    exp_trig = 0;
    reset = 1'b0;
    wait_to(s + 3); chk("post_rst_idle", bus.busy, 0);
    wait_to(s + 4); chk("post_rst_deb", bus.busy, 1);
    wait_to(s + 12);
    chk("post_rst_notrig", bus.trig_count, 0);
    bus.frame_valid = 1'b0;
    wait_to(s + 15);
    f = cyc;
    bus.frame_valid = 1'b1;
    push_pulse(f + 3, 3);
    wait_to(f + 7);
    release_chk();

    wait_to(cyc + 10);
    chk("pending", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
